// File: rtl/monopix_ro_sched.sv
// Round-robin FREEZE/READ/DATA scheduler for the four MONOPIX flavours.
// Define MONOPIX_RO_SCHED_CNT_EN to build the saturating completed-transaction counter.
module monopix_ro_sched #(
  parameter int WAIT_LEN = 3,
  parameter int READ_LEN = 2,
  parameter int DATA_LEN = 6
) (
  input  logic        clk_bx,
  input  logic        reset,
  input  logic [3:0]  en,
  input  logic [3:0]  token,
  output logic [3:0]  freeze,
  output logic [3:0]  read,
  output logic [1:0]  gnt_id,
  output logic        busy,
  output logic        data_start,
  output logic [15:0] rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TOKEN_WAIT,
    S_READ,
    S_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  req;
  logic [7:0]  len_m1;
  logic        phase_done;

  logic [3:0]  freeze_q, freeze_d;
  logic [3:0]  read_q, read_d;
  logic [1:0]  gnt_id_q, gnt_id_d;
  logic        busy_q, busy_d;
  logic        data_start_q, data_start_d;

  // Search begins one past the previous grant; the previous grant has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    req = token & en;
    case (state_q)
      S_TOKEN_WAIT: len_m1 = 8'(WAIT_LEN - 1);
      S_READ:       len_m1 = 8'(READ_LEN - 1);
      default:      len_m1 = 8'(DATA_LEN - 1);
    endcase
    phase_done = (cnt_q == len_m1);

    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (req != 4'd0) begin
          gnt_d   = rr_pick(req, last_q);
          state_d = S_TOKEN_WAIT;
        end
      end
      S_TOKEN_WAIT: begin
        if (phase_done) begin
          cnt_d   = 8'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (phase_done) begin
          cnt_d   = 8'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (phase_done) begin
          cnt_d  = 8'd0;
          last_d = gnt_q;
          if (req != 4'd0) begin
            gnt_d   = rr_pick(req, gnt_q);
            state_d = S_TOKEN_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    freeze_d     = ((state_q == S_TOKEN_WAIT) || (state_q == S_READ)) ? (4'b0001 << gnt_q) : 4'd0;
    read_d       = (state_q == S_READ) ? (4'b0001 << gnt_q) : 4'd0;
    data_start_d = (state_q == S_DATA) && (cnt_q == 8'd0);
    busy_d       = (state_q != S_IDLE);
    gnt_id_d     = gnt_q;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      gnt_q        <= 2'd0;
      last_q       <= 2'd3;
      freeze_q     <= 4'd0;
      read_q       <= 4'd0;
      gnt_id_q     <= 2'd0;
      busy_q       <= 1'b0;
      data_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      freeze_q     <= freeze_d;
      read_q       <= read_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      data_start_q <= data_start_d;
    end
  end

  assign freeze     = freeze_q;
  assign read       = read_q;
  assign gnt_id     = gnt_id_q;
  assign busy       = busy_q;
  assign data_start = data_start_q;

`ifdef MONOPIX_RO_SCHED_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        txn_done;

  always_comb begin
    txn_done = (state_q == S_DATA) && phase_done;
    rd_cnt_d = rd_cnt_q;
    if (txn_done && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) rd_cnt_q <= 16'd0;
    else       rd_cnt_q <= rd_cnt_d;
  end

  assign rd_cnt = rd_cnt_q;
`else
  assign rd_cnt = 16'h0000;
`endif

endmodule
